// File: rtl/exe_mem_pipe_skid_pkg.sv
// Shared defaults and helpers for the EX->MEM pipeline register with skid buffer.
// The lane count, data width and register address width are the defaults used by the top module.
package exe_mem_pipe_skid_pkg;

  localparam int unsigned LANES_DEF   = 2;
  localparam int unsigned D_WIDTH_DEF = 32;
  localparam int unsigned WA_W_DEF    = 4;

  // Number of slots between EX and MEM: one main slot and one skid slot.
  localparam int unsigned SLOT_COUNT  = 2;

endpackage

// File: rtl/exe_mem_pipe_skid_lane_kill.sv
// Kill mask for younger lanes in a bundle.
// A lane is killed when any older valid lane in the same bundle takes a branch.
module lane_kill_mask #(
  parameter int unsigned LANES = 2
) (
  input  logic [LANES-1:0] lane_vld,
  input  logic [LANES-1:0] pcsrc,
  output logic [LANES-1:0] kill
);

  // Prefix OR of the taken branches in older lanes; lane 0 is never killed.
  always_comb begin : prefix_or
    logic taken;
    taken = 1'b0;
    kill  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      kill[i] = taken;
      taken   = taken | (lane_vld[i] & pcsrc[i]);
    end
  end

endmodule

// File: rtl/exe_mem_pipe_skid.sv
// N-lane EX->MEM pipeline register with a 2-entry skid buffer.
// Adds synchronous flush and kills lanes that sit behind a taken branch in the same bundle.
module exe_mem_pipe_skid
  import exe_mem_pipe_skid_pkg::*;
#(
  parameter int unsigned LANES   = LANES_DEF,
  parameter int unsigned D_WIDTH = D_WIDTH_DEF,
  parameter int unsigned WA_W    = WA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [LANES-1:0]         i_lane_vld,
  input  logic [LANES-1:0]         i_pcsrc,
  input  logic [LANES-1:0]         i_regwrite,
  input  logic [LANES-1:0]         i_memtoreg,
  input  logic [LANES-1:0]         i_memwrite,
  input  logic [LANES*D_WIDTH-1:0] i_alu_result,
  input  logic [LANES*D_WIDTH-1:0] i_write_data,
  input  logic [LANES*WA_W-1:0]    i_wa3,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [LANES-1:0]         o_lane_vld,
  output logic [LANES-1:0]         o_pcsrc,
  output logic [LANES-1:0]         o_regwrite,
  output logic [LANES-1:0]         o_memtoreg,
  output logic [LANES-1:0]         o_memwrite,
  output logic [LANES*D_WIDTH-1:0] o_alu_result,
  output logic [LANES*D_WIDTH-1:0] o_write_data,
  output logic [LANES*WA_W-1:0]    o_wa3
);

  typedef struct packed {
    logic                     vld;
    logic [LANES-1:0]         lane_vld;
    logic [LANES-1:0]         pcsrc;
    logic [LANES-1:0]         regwrite;
    logic [LANES-1:0]         memtoreg;
    logic [LANES-1:0]         memwrite;
    logic [LANES*D_WIDTH-1:0] alu_result;
    logic [LANES*D_WIDTH-1:0] write_data;
    logic [LANES*WA_W-1:0]    wa3;
  } slot_t;

  // Invalidate a slot: valid and control bits drop, data fields hold.
  function automatic slot_t clear_ctrl(input slot_t s);
    slot_t r;
    r          = s;
    r.vld      = 1'b0;
    r.lane_vld = '0;
    r.pcsrc    = '0;
    r.regwrite = '0;
    r.memtoreg = '0;
    r.memwrite = '0;
    return r;
  endfunction

  logic [LANES-1:0] kill_c;
  logic [LANES-1:0] cv_c;
  slot_t            in_c;
  logic             bubble_c;
  logic             in_fire_c;
  logic             out_fire_c;

  slot_t            m_q;
  slot_t            s_q;
  slot_t            m_d;
  slot_t            s_d;
  logic             ready_q;
  logic             ready_d;

  lane_kill_mask #(
    .LANES (LANES)
  ) u_kill (
    .lane_vld (i_lane_vld),
    .pcsrc    (i_pcsrc),
    .kill     (kill_c)
  );

  // Captured bundle: control bits are gated by the surviving lane valid, data passes ungated.
  always_comb begin
    cv_c                = i_lane_vld & ~kill_c;
    in_c.vld            = 1'b1;
    in_c.lane_vld       = cv_c;
    in_c.pcsrc          = i_pcsrc & cv_c;
    in_c.regwrite       = i_regwrite & cv_c;
    in_c.memtoreg       = i_memtoreg & cv_c;
    in_c.memwrite       = i_memwrite & cv_c;
    in_c.alu_result     = i_alu_result;
    in_c.write_data     = i_write_data;
    in_c.wa3            = i_wa3;
    bubble_c            = ~|cv_c;
    in_fire_c           = i_valid & ready_q;
    out_fire_c          = m_q.vld & i_ready;
  end

  // Slot update; o_ready tracks the next skid occupancy so it never depends on i_ready combinationally.
  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    ready_d = ready_q;
    if (i_flush) begin
      m_d     = clear_ctrl(m_q);
      s_d     = clear_ctrl(s_q);
      ready_d = 1'b1;
    end else if (s_q.vld && out_fire_c) begin
      m_d     = s_q;
      s_d     = clear_ctrl(s_q);
      ready_d = 1'b1;
    end else if (in_fire_c && !bubble_c && (!m_q.vld || out_fire_c)) begin
      m_d     = in_c;
    end else if (in_fire_c && !bubble_c) begin
      s_d     = in_c;
      ready_d = 1'b0;
    end else if (out_fire_c) begin
      m_d     = clear_ctrl(m_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q     <= '0;
      s_q     <= '0;
      ready_q <= 1'b1;
    end else begin
      m_q     <= m_d;
      s_q     <= s_d;
      ready_q <= ready_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_valid      = m_q.vld;
  assign o_lane_vld   = m_q.lane_vld;
  assign o_pcsrc      = m_q.pcsrc;
  assign o_regwrite   = m_q.regwrite;
  assign o_memtoreg   = m_q.memtoreg;
  assign o_memwrite   = m_q.memwrite;
  assign o_alu_result = m_q.alu_result;
  assign o_write_data = m_q.write_data;
  assign o_wa3        = m_q.wa3;

endmodule

// File: tb/tb_exe_mem_pipe_skid.sv
// Self-checking bench for exe_mem_pipe_skid: directed scenarios then random traffic,
// compared against an in-order bundle queue of capacity two.
module tb_exe_mem_pipe_skid;

  localparam int unsigned L = 2;
  localparam int unsigned D = 32;
  localparam int unsigned W = 4;

  logic           clk;
  logic           rst_n;
  logic           i_flush;
  logic           i_valid;
  logic           o_ready;
  logic [L-1:0]   i_lane_vld;
  logic [L-1:0]   i_pcsrc;
  logic [L-1:0]   i_regwrite;
  logic [L-1:0]   i_memtoreg;
  logic [L-1:0]   i_memwrite;
  logic [L*D-1:0] i_alu_result;
  logic [L*D-1:0] i_write_data;
  logic [L*W-1:0] i_wa3;
  logic           o_valid;
  logic           i_ready;
  logic [L-1:0]   o_lane_vld;
  logic [L-1:0]   o_pcsrc;
  logic [L-1:0]   o_regwrite;
  logic [L-1:0]   o_memtoreg;
  logic [L-1:0]   o_memwrite;
  logic [L*D-1:0] o_alu_result;
  logic [L*D-1:0] o_write_data;
  logic [L*W-1:0] o_wa3;

  exe_mem_pipe_skid #(
    .LANES   (L),
    .D_WIDTH (D),
    .WA_W    (W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (i_flush),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_lane_vld   (i_lane_vld),
    .i_pcsrc      (i_pcsrc),
    .i_regwrite   (i_regwrite),
    .i_memtoreg   (i_memtoreg),
    .i_memwrite   (i_memwrite),
    .i_alu_result (i_alu_result),
    .i_write_data (i_write_data),
    .i_wa3        (i_wa3),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_lane_vld   (o_lane_vld),
    .o_pcsrc      (o_pcsrc),
    .o_regwrite   (o_regwrite),
    .o_memtoreg   (o_memtoreg),
    .o_memwrite   (o_memwrite),
    .o_alu_result (o_alu_result),
    .o_write_data (o_write_data),
    .o_wa3        (o_wa3)
  );

  typedef struct packed {
    logic [L-1:0]   lane_vld;
    logic [L-1:0]   pcsrc;
    logic [L-1:0]   regwrite;
    logic [L-1:0]   memtoreg;
    logic [L-1:0]   memwrite;
    logic [L*D-1:0] alu;
    logic [L*D-1:0] wd;
    logic [L*W-1:0] wa3;
  } bun_t;

  bun_t q[$];
  bit   exp_ready;
  int   tests;
  int   fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Bundle as MEM should see it: lanes behind an older taken branch are dropped.
  function automatic bun_t ref_capture();
    bun_t b;
    b.alu = i_alu_result;
    b.wd  = i_write_data;
    b.wa3 = i_wa3;
    for (int i = 0; i < int'(L); i++) begin
      bit killed = 1'b0;
      bit live;
      for (int j = 0; j < i; j++)
        if (i_lane_vld[j] && i_pcsrc[j]) killed = 1'b1;
      live          = i_lane_vld[i] && !killed;
      b.lane_vld[i] = live;
      b.pcsrc[i]    = i_pcsrc[i] && live;
      b.regwrite[i] = i_regwrite[i] && live;
      b.memtoreg[i] = i_memtoreg[i] && live;
      b.memwrite[i] = i_memwrite[i] && live;
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("o_valid", 64'(o_valid), 64'(q.size() != 0));
    chk("o_ready", 64'(o_ready), 64'(exp_ready));
    if (q.size() != 0) begin
      chk("o_lane_vld", 64'(o_lane_vld), 64'(q[0].lane_vld));
      chk("o_pcsrc", 64'(o_pcsrc), 64'(q[0].pcsrc));
      chk("o_regwrite", 64'(o_regwrite), 64'(q[0].regwrite));
      chk("o_memtoreg", 64'(o_memtoreg), 64'(q[0].memtoreg));
      chk("o_memwrite", 64'(o_memwrite), 64'(q[0].memwrite));
      chk("o_alu_result", o_alu_result, q[0].alu);
      chk("o_write_data", o_write_data, q[0].wd);
      chk("o_wa3", 64'(o_wa3), 64'(q[0].wa3));
    end else begin
      chk("idle_ctrl", 64'({o_lane_vld, o_pcsrc, o_regwrite, o_memtoreg, o_memwrite}), 64'(0));
    end
  endtask

  // One clock: update the queue model from the inputs seen at the edge, then check.
  task automatic cycle();
    bit   out_f;
    bit   in_f;
    bun_t cap;
    out_f = (q.size() != 0) && i_ready;
    in_f  = i_valid && exp_ready;
    cap   = ref_capture();
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
    end else if (i_flush) begin
      q.delete();
    end else begin
      if (out_f) void'(q.pop_front());
      if (in_f && cap.lane_vld != '0) q.push_back(cap);
    end
    exp_ready = (q.size() < 2);
    #1;
    check_outputs();
  endtask

  task automatic rnd_fields();
    i_lane_vld   = L'($urandom);
    i_pcsrc      = L'($urandom_range(0, 3) == 0 ? $urandom : 0);
    i_regwrite   = L'($urandom);
    i_memtoreg   = L'($urandom);
    i_memwrite   = L'($urandom);
    i_alu_result = {32'($urandom), 32'($urandom)};
    i_write_data = {32'($urandom), 32'($urandom)};
    i_wa3        = (L*W)'($urandom);
  endtask

  task automatic drive(input logic [1:0] lv, input logic [1:0] pc, input logic [1:0] rw,
                       input logic [1:0] mw, input logic [31:0] a0, input logic [31:0] a1);
    i_valid      = 1'b1;
    i_lane_vld   = lv;
    i_pcsrc      = pc;
    i_regwrite   = rw;
    i_memtoreg   = 2'b00;
    i_memwrite   = mw;
    i_alu_result = {a1, a0};
    i_write_data = {32'($urandom), 32'($urandom)};
    i_wa3        = (L*W)'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(o_valid), 64'(0));
    chk({tag, "_ready"}, 64'(o_ready), 64'(1));
    chk({tag, "_ctrl"}, 64'({o_lane_vld, o_pcsrc, o_regwrite, o_memtoreg, o_memwrite}), 64'(0));
    chk({tag, "_alu"}, o_alu_result, 64'(0));
    chk({tag, "_wd"}, o_write_data, 64'(0));
    chk({tag, "_wa3"}, 64'(o_wa3), 64'(0));
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    exp_ready = 1'b1;
    rst_n     = 1'b0;
    i_flush   = 1'b0;
    i_ready   = 1'b1;
    i_valid   = 1'b1;
    rnd_fields();

    // Reset held with random inputs.
    repeat (3) begin
      @(posedge clk);
      #1;
      i_valid = 1'($urandom);
      i_flush = 1'($urandom);
      rnd_fields();
    end
    check_all_zero("rst");

    // Release: nothing moves until the first accepted bundle.
    i_valid = 1'b0;
    i_flush = 1'b0;
    rst_n   = 1'b1;
    repeat (2) cycle();
    check_all_zero("post_rst");

    // Streaming at full throughput.
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 2'b00, 2'b11, 2'b00, 32'(16 * (k + 1)), 32'($urandom));
      cycle();
      chk("stream_alu0", 64'(o_alu_result[31:0]), 64'(16 * (k + 1)));
      chk("stream_ready", 64'(o_ready), 64'(1));
    end
    i_valid = 1'b0;
    cycle();

    // Skid: A held in the main slot, B absorbed, then both drain in order.
    i_ready = 1'b0;
    drive(2'b01, 2'b00, 2'b01, 2'b00, 32'h10, 32'h0);
    cycle();
    drive(2'b01, 2'b00, 2'b01, 2'b00, 32'h20, 32'h0);
    cycle();
    chk("skid_ready", 64'(o_ready), 64'(0));
    chk("skid_hold_a", 64'(o_alu_result[31:0]), 64'h10);
    i_valid = 1'b0;
    cycle();
    chk("skid_still_a", 64'(o_alu_result[31:0]), 64'h10);
    i_ready = 1'b1;
    cycle();
    chk("skid_b", 64'(o_alu_result[31:0]), 64'h20);
    chk("skid_ready_back", 64'(o_ready), 64'(1));
    cycle();

    // Lane kill behind a taken branch in lane 0.
    drive(2'b11, 2'b01, 2'b11, 2'b10, 32'h1111, 32'hABCD);
    cycle();
    chk("kill_lane_vld", 64'(o_lane_vld), 64'(2'b01));
    chk("kill_regwrite", 64'(o_regwrite), 64'(2'b01));
    chk("kill_memwrite", 64'(o_memwrite), 64'(2'b00));
    chk("kill_pcsrc", 64'(o_pcsrc), 64'(2'b01));
    chk("kill_alu1", 64'(o_alu_result[63:32]), 64'hABCD);
    i_valid = 1'b0;
    cycle();

    // Flush with both slots occupied and an input in the same cycle.
    i_ready = 1'b0;
    drive(2'b11, 2'b00, 2'b11, 2'b01, 32'h30, 32'h31);
    cycle();
    drive(2'b11, 2'b00, 2'b11, 2'b01, 32'h40, 32'h41);
    cycle();
    i_valid = 1'b1;
    i_flush = 1'b1;
    cycle();
    chk("flush_valid", 64'(o_valid), 64'(0));
    chk("flush_ready", 64'(o_ready), 64'(1));
    i_flush = 1'b0;
    i_ready = 1'b1;
    drive(2'b01, 2'b00, 2'b01, 2'b00, 32'h50, 32'h0);
    cycle();
    chk("flush_c", 64'(o_alu_result[31:0]), 64'h50);
    i_valid = 1'b0;
    cycle();
    chk("flush_c_alone", 64'(o_valid), 64'(0));

    // Bubbles: all lanes invalid, and both lanes branching.
    drive(2'b00, 2'b00, 2'b11, 2'b11, 32'h60, 32'h61);
    cycle();
    chk("bubble_valid", 64'(o_valid), 64'(0));
    chk("bubble_ready", 64'(o_ready), 64'(1));
    drive(2'b11, 2'b11, 2'b11, 2'b00, 32'h70, 32'h71);
    cycle();
    chk("dual_br_lane_vld", 64'(o_lane_vld), 64'(2'b01));
    i_valid = 1'b0;
    cycle();

    // Random traffic with occasional flush.
    for (int n = 0; n < 1500; n++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 2) != 0);
      i_flush = ($urandom_range(0, 39) == 0);
      rnd_fields();
      cycle();
    end

    // Asynchronous reset while stalled with both slots full.
    i_flush = 1'b0;
    i_ready = 1'b0;
    drive(2'b11, 2'b00, 2'b11, 2'b11, 32'h80, 32'h81);
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    exp_ready = 1'b1;
    check_all_zero("mid_rst");
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    rst_n   = 1'b1;
    i_ready = 1'b1;
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
